// File: rtl/conv_row_sequencer.sv
// Row-level sequencer for the 3x3 row-stationary PE array and its inter-row psum FIFOs.
// Walks one ifm map row by row (GAP/ROW per row), then drains the last FIFO.
module conv_row_sequencer #(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_LEN     = 9,
  parameter int NUM_ROWS    = 5,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk2,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   ifm_valid,
  output logic                   set_reg,
  output logic                   set_wgt,
  output logic                   set_ifm,
  output logic                   wgt_load,
  output logic [KERNEL_SIZE-1:0] wr_en,
  output logic [KERNEL_SIZE-1:0] rd_en,
  output logic                   wr_clr,
  output logic                   rd_clr,
  output logic [CNT_WIDTH-1:0]   row_idx,
  output logic [CNT_WIDTH-1:0]   col_idx,
  output logic                   busy,
  output logic                   done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_ROW   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] COL_LAST   = CNT_WIDTH'(ROW_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST   = CNT_WIDTH'(NUM_ROWS - 1);
  localparam logic [CNT_WIDTH-1:0] RD_LAST    = CNT_WIDTH'(ROW_LEN - KERNEL_SIZE);
  localparam logic [CNT_WIDTH-1:0] RD_CLR_COL = CNT_WIDTH'(ROW_LEN - KERNEL_SIZE + 1);
  localparam logic [CNT_WIDTH-1:0] WR_FIRST   = CNT_WIDTH'(KERNEL_SIZE);

  logic [2:0]           state, state_nx;
  logic [CNT_WIDTH-1:0] row, row_nx;
  logic [CNT_WIDTH-1:0] col, col_nx;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    if (abort) begin
      state_nx = S_IDLE;
      row_nx   = '0;
      col_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nx = S_GAP;
            row_nx   = '0;
            col_nx   = '0;
          end
        end
        S_GAP: begin
          state_nx = S_ROW;
          col_nx   = '0;
        end
        S_ROW: begin
          if (ifm_valid) begin
            if (col == COL_LAST) begin
              col_nx = '0;
              if (row < ROW_LAST) begin
                state_nx = S_GAP;
                row_nx   = row + 1'b1;
              end else begin
                state_nx = S_DRAIN;
              end
            end else begin
              col_nx = col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (ifm_valid) begin
            if (col == COL_LAST) state_nx = S_DONE;
            else                 col_nx   = col + 1'b1;
          end
        end
        S_DONE: begin
          state_nx = S_IDLE;
          row_nx   = '0;
          col_nx   = '0;
        end
        default: begin
          state_nx = S_IDLE;
          row_nx   = '0;
          col_nx   = '0;
        end
      endcase
    end
  end

  // Enables are decoded from registered state; only ifm_valid gates them combinationally.
  always_comb begin
    set_reg  = 1'b0;
    set_wgt  = 1'b0;
    set_ifm  = 1'b0;
    wgt_load = 1'b0;
    wr_en    = '0;
    rd_en    = '0;
    wr_clr   = 1'b0;
    rd_clr   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_GAP: begin
        busy     = 1'b1;
        wgt_load = 1'b1;
      end
      S_ROW: begin
        busy = 1'b1;
        if (ifm_valid) begin
          set_reg = 1'b1;
          set_wgt = 1'b1;
          set_ifm = 1'b1;
          wr_clr  = (col == '0) && (row != '0);
          rd_clr  = (col == RD_CLR_COL) && (row != '0);
          // Row r reads the r FIFOs filled by earlier rows and writes r+1, capped at KERNEL_SIZE.
          for (int unsigned j = 0; j < KERNEL_SIZE; j++) begin
            rd_en[j] = (row > CNT_WIDTH'(j)) && (col <= RD_LAST);
            wr_en[j] = (row >= CNT_WIDTH'(j)) && (col >= WR_FIRST);
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (ifm_valid) begin
          set_reg                = 1'b1;
          rd_en[KERNEL_SIZE-1]   = 1'b1;
          wr_clr                 = (col == '0);
        end
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign row_idx = row;
  assign col_idx = col;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Scoreboard bench for conv_row_sequencer: a timeline model (cycles since start)
// predicts every output per cycle; predictions are queued and checked mid-cycle.
module tb_conv_row_sequencer;

  localparam int K   = 3;
  localparam int RL  = 9;
  localparam int NR  = 5;
  localparam int CW  = 8;
  localparam int PER      = RL + 1;
  localparam int ROWS_END = NR * PER;
  localparam int DONE_K   = ROWS_END + RL + 1;

  typedef struct packed {
    logic          set_reg;
    logic          set_wgt;
    logic          set_ifm;
    logic          wgt_load;
    logic [K-1:0]  wr_en;
    logic [K-1:0]  rd_en;
    logic          wr_clr;
    logic          rd_clr;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          busy;
    logic          done;
  } exp_t;

  logic          clk2 = 1'b0;
  logic          rst_n;
  logic          start, abort, ifm_valid;
  logic          set_reg, set_wgt, set_ifm, wgt_load, wr_clr, rd_clr, busy, done;
  logic [K-1:0]  wr_en, rd_en;
  logic [CW-1:0] row_idx, col_idx;

  int   n_vec = 0;
  int   n_err = 0;
  int   m_k   = 0;
  exp_t sb[$];

  conv_row_sequencer #(
    .KERNEL_SIZE(K),
    .ROW_LEN    (RL),
    .NUM_ROWS   (NR),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk2     (clk2),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .ifm_valid(ifm_valid),
    .set_reg  (set_reg),
    .set_wgt  (set_wgt),
    .set_ifm  (set_ifm),
    .wgt_load (wgt_load),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .wr_clr   (wr_clr),
    .rd_clr   (rd_clr),
    .row_idx  (row_idx),
    .col_idx  (col_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk2 = ~clk2;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // k = cycles since the start edge: GAP at 1+r*PER, ROW cols follow, then DRAIN, then DONE.
  function automatic exp_t model_out(int k, logic v);
    exp_t e;
    int m, r, c;
    e = '0;
    if (k >= 1 && k <= ROWS_END) begin
      m = k - 1;
      r = m / PER;
      c = m % PER;
      e.busy = 1'b1;
      e.row  = CW'(r);
      if (c == 0) begin
        e.wgt_load = 1'b1;
      end else begin
        c     = c - 1;
        e.col = CW'(c);
        if (v) begin
          e.set_reg = 1'b1;
          e.set_wgt = 1'b1;
          e.set_ifm = 1'b1;
          e.wr_clr  = (c == 0) && (r > 0);
          e.rd_clr  = (c == RL - K + 1) && (r > 0);
          for (int j = 0; j < K; j++) begin
            e.rd_en[j] = (j < r) && (c <= RL - K);
            e.wr_en[j] = (j < r + 1) && (c >= K);
          end
        end
      end
    end else if (k > ROWS_END && k < DONE_K) begin
      c      = k - ROWS_END - 1;
      e.busy = 1'b1;
      e.row  = CW'(NR - 1);
      e.col  = CW'(c);
      if (v) begin
        e.set_reg      = 1'b1;
        e.rd_en[K-1]   = 1'b1;
        e.wr_clr       = (c == 0);
      end
    end else if (k == DONE_K) begin
      e.done = 1'b1;
      e.row  = CW'(NR - 1);
      e.col  = CW'(RL - 1);
    end
    return e;
  endfunction

  function automatic int model_next(int k, logic st, logic ab, logic v);
    if (ab) return 0;
    if (k == 0) return st ? 1 : 0;
    if (k == DONE_K) return 0;
    if (k > ROWS_END || ((k - 1) % PER) != 0) begin
      if (!v) return k;
    end
    return k + 1;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic st, input logic ab, input logic v, output logic dn);
    exp_t e;
    start     = st;
    abort     = ab;
    ifm_valid = v;
    sb.push_back(model_out(m_k, v));
    @(negedge clk2);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("set_reg",  32'(set_reg),  32'(e.set_reg));
      chk("set_wgt",  32'(set_wgt),  32'(e.set_wgt));
      chk("set_ifm",  32'(set_ifm),  32'(e.set_ifm));
      chk("wgt_load", 32'(wgt_load), 32'(e.wgt_load));
      chk("wr_en",    32'(wr_en),    32'(e.wr_en));
      chk("rd_en",    32'(rd_en),    32'(e.rd_en));
      chk("wr_clr",   32'(wr_clr),   32'(e.wr_clr));
      chk("rd_clr",   32'(rd_clr),   32'(e.rd_clr));
      chk("row_idx",  32'(row_idx),  32'(e.row));
      chk("col_idx",  32'(col_idx),  32'(e.col));
      chk("busy",     32'(busy),     32'(e.busy));
      chk("done",     32'(done),     32'(e.done));
    end
    dn  = done;
    m_k = model_next(m_k, st, ab, v);
    @(posedge clk2);
    #1;
  endtask

  // done_exp: cycle index of done (-1: must never pulse, -2: any cycle, but it must pulse)
  task automatic run_map(input int stall_at, input int stall_n, input int abort_at,
                         input int extra_start_at, input int done_exp, input bit rnd,
                         input int ncyc);
    int   done_seen;
    logic st, ab, v, dn;
    done_seen = -1;
    for (int i = 0; i < ncyc; i++) begin
      st = (i == 0) || (i == extra_start_at);
      ab = (i == abort_at);
      if (rnd) v = ($urandom_range(0, 3) != 0);
      else     v = !(i >= stall_at && i < stall_at + stall_n);
      step(st, ab, v, dn);
      if (dn && done_seen < 0) done_seen = i;
    end
    if (done_exp == -2) chk("done_seen", 32'(done_seen >= 0), 32'd1);
    else                chk("done_at", 32'(done_seen), 32'(done_exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {set_reg, set_wgt, set_ifm, wgt_load, wr_en, rd_en, wr_clr, rd_clr, busy, done}, 32'd0);
    chk({tag, "_idx"}, {row_idx, col_idx}, 32'd0);
  endtask

  initial begin
    logic dn;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    ifm_valid = 1'b0;
    repeat (2) @(posedge clk2);
    #1;
    chk_all_zero("reset_outs");
    @(negedge clk2);
    rst_n = 1'b1;
    @(posedge clk2);
    #1;

    // Full map with a start pulse mid-ROW that must be ignored.
    run_map(-1, 0, -1, 25, DONE_K, 1'b0, DONE_K + 4);
    // Three stall cycles at row 1 col 4.
    run_map(1 + PER + 1 + 4, 3, -1, -1, DONE_K + 3, 1'b0, DONE_K + 6);
    // Abort at row 3 col 5; then a clean restart.
    run_map(-1, 0, 1 + 3 * PER + 1 + 5, -1, -1, 1'b0, 45);
    run_map(-1, 0, -1, -1, DONE_K, 1'b0, DONE_K + 2);

    // start and abort together in IDLE.
    step(1'b1, 1'b1, 1'b1, dn);
    repeat (3) step(1'b0, 1'b0, 1'b1, dn);

    // Random ifm_valid, including low during GAP and IDLE.
    run_map(-1, 0, -1, -1, -2, 1'b1, 150);

    // Async reset asserted mid-ROW.
    step(1'b1, 1'b0, 1'b1, dn);
    repeat (15) step(1'b0, 1'b0, 1'b1, dn);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk2);
    rst_n = 1'b1;
    m_k   = 0;
    @(posedge clk2);
    #1;
    repeat (2) step(1'b0, 1'b0, 1'b1, dn);
    run_map(-1, 0, -1, -1, DONE_K, 1'b0, DONE_K + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_row_sequencer.md
# conv_row_sequencer

Row-level sequencer for the 3x3 row-stationary PE array and its inter-row psum FIFOs in `TOP`. It replaces hand-driven stimulus by generating `set_reg`, `set_wgt`, `set_ifm`, the per-FIFO `wr_en`/`rd_en` vectors and the `wr_clr`/`rd_clr` pointer clears. It sequences one full input feature map, streamed row by row, followed by a drain pass. It sits between the host/DMA start logic and `TOP`, on the `clk2` domain.

## Interface
- KERNEL_SIZE, 3: kernel rows/cols; also the number of psum FIFOs.
- ROW_LEN, 9: ifm elements per row; must be ≥ 2*KERNEL_SIZE.
- NUM_ROWS, 5: ifm rows per map; must be ≥ KERNEL_SIZE.
- CNT_WIDTH, 8: width of the row and column counters; must hold max(ROW_LEN, NUM_ROWS).

Ports:
- clk2  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a map; sampled only in IDLE.
- abort  in  1  synchronous abort; forces IDLE next edge.
- ifm_valid  in  1  current ifm element valid; low stalls ROW/DRAIN.
- set_reg  out  1  PE accumulate enable.
- set_wgt  out  1  PE weight-register load.
- set_ifm  out  1  PE ifm-register load.
- wgt_load  out  1  request the next weight word from upstream (GAP cycle).
- wr_en  out  KERNEL_SIZE  bit j drives `wr_en_j` of FIFO j.
- rd_en  out  KERNEL_SIZE  bit j drives `rd_en_j` of FIFO j.
- wr_clr  out  1  FIFO write-pointer clear.
- rd_clr  out  1  FIFO read-pointer clear.
- row_idx  out  CNT_WIDTH  current ifm row.
- col_idx  out  CNT_WIDTH  current column.
- busy  out  1  high in GAP, ROW and DRAIN.
- done  out  1  one-cycle pulse at end of map.

## Operation
- FSM states: IDLE, GAP, ROW, DRAIN, DONE.
- Outputs are Moore decodes of registered state and counters; outputs carry no direct combinational path from inputs, except the `ifm_valid` gating described below.
- Reset value of every output is 0; the FSM resets to IDLE with row=0, col=0.

IDLE
- All outputs 0.
- start=1 and abort=0 → GAP with row=0.

GAP (1 cycle, once per row)
- wgt_load=1; every other enable 0.
- Next state: ROW, col=0.

ROW (row r, column c)
- Outputs active only when ifm_valid=1. With ifm_valid=0, every enable is 0 and the counters hold.
- set_reg=set_wgt=set_ifm=1.
- wr_clr=1 at c==0, only when r>0.
- rd_en[j]=1 for j < min(r, KERNEL_SIZE) while c ≤ ROW_LEN-KERNEL_SIZE.
- rd_clr=1 at c==ROW_LEN-KERNEL_SIZE+1, only when r>0.
- wr_en[j]=1 for j < min(r+1, KERNEL_SIZE) while c ≥ KERNEL_SIZE.
- Transitions on c==ROW_LEN-1 with a valid beat:
  - r<NUM_ROWS-1 → GAP, row+1.
  - otherwise → DRAIN, col=0.

DRAIN (ROW_LEN valid beats)
- set_reg=1.
- rd_en[KERNEL_SIZE-1]=1 for all c.
- wr_clr=1 at c==0.
- Same stall rule as ROW.
- Last beat → DONE.

DONE (1 cycle)
- done=1, busy=0.
- Next state: IDLE.

Boundary rules
- abort has priority over every other condition. From any state → IDLE next edge with counters zeroed. Outputs are 0 from that edge on.
- start while busy is ignored.
- start and abort both high in IDLE: abort wins; stay IDLE.
- Column arithmetic is unsigned. Counters never wrap: col stops at ROW_LEN-1, row stops at NUM_ROWS-1.

## Timing
- start sampled high at edge t:
  - GAP visible in cycle t+1.
  - Row r column 0 at cycle t+2+r*(ROW_LEN+1), with no stalls.
- Total duration, no stalls: done pulses at cycle t+1+NUM_ROWS*(ROW_LEN+1)+ROW_LEN. With defaults that is t+60.
- Each stalled cycle in ROW or DRAIN delays done by exactly one cycle. ifm_valid is ignored in IDLE, GAP and DONE.
- Back-to-back maps: start high in the DONE cycle is not sampled. The earliest accepted start is the first IDLE cycle.

## Test plan
- Reset: assert rst_n=0 mid-ROW → all outputs 0 immediately (async); after release, FSM is in IDLE with busy=0.
- Full map, defaults, ifm_valid=1, start at edge 0:
  - wgt_load high at cycles 1, 11, 21, 31, 41.
  - DRAIN spans cycles 51–59.
  - done=1 only at cycle 60.
  - busy high at cycles 1–59.
- Row 2 decode: rd_en=3'b011 at cols 0–6; rd_clr at col 7; wr_clr at col 0; wr_en=3'b111 at cols 3–8. Row 0: rd_en=0, wr_en=3'b001 at cols 3–8, no clears.
- Stall: ifm_valid=0 for 3 cycles at row 1 col 4 → col_idx holds 4 and all enables are 0 during the stall. done moves to cycle 63.
- Abort: abort=1 at row 3 col 5 → next cycle IDLE, all outputs 0, done never pulses. A subsequent start restarts at row 0 GAP.
- Protocol corners:
  - start pulsed during ROW → ignored; done still at cycle 60.
  - start+abort together in IDLE → stays IDLE.
